// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//
// Decode-to-execute boundary in front of the 3-bit-controlled ALU. It holds
// the integer register file and reads rs1/rs2. A read returns the EX result
// when the instruction currently in the slot writes that register, otherwise
// the write-back value when one is in flight, otherwise the register file.
// Operand B is either the immediate or the resolved rs2 value. Operands and
// ALU control sit in a single valid/ready slot that drives the ALU directly.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   decode-side handshake (in_ready is combinational)
//   in_rs1/in_rs2/in_rd register addresses of the incoming instruction
//   in_imm              sign-extended immediate
//   in_alu_src          1: B = in_imm, 0: B = resolved rs2
//   in_alu_control      ALU op code, passed through
//   in_reg_write        incoming instruction writes rd
//   ex_result           combinational ALU result of the slot's instruction
//   wb_en/addr/data     register-file write port
//   flush               kills the slot and the incoming instruction
//   out_ready/out_valid execute-side handshake
//   out_alu_control, out_A, out_B, out_rs2_val, out_rd, out_reg_write
//                       registered slot contents
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [$clog2(NREG)-1:0] in_rs1,
    input  logic [$clog2(NREG)-1:0] in_rs2,
    input  logic [$clog2(NREG)-1:0] in_rd,
    input  logic [XLEN-1:0]         in_imm,
    input  logic                    in_alu_src,
    input  logic [2:0]              in_alu_control,
    input  logic                    in_reg_write,
    input  logic [XLEN-1:0]         ex_result,
    input  logic                    wb_en,
    input  logic [$clog2(NREG)-1:0] wb_addr,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    flush,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [2:0]              out_alu_control,
    output logic [XLEN-1:0]         out_A,
    output logic [XLEN-1:0]         out_B,
    output logic [XLEN-1:0]         out_rs2_val,
    output logic [$clog2(NREG)-1:0] out_rd,
    output logic                    out_reg_write
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];

    logic [XLEN-1:0] rs1_val_p0;
    logic [XLEN-1:0] rs2_val_p0;
    logic [XLEN-1:0] b_val_p0;
    logic            accept_p0;

    // Source priority: x0, then the slot's own result (youngest producer),
    // then the write-back in flight, then the stored register.
    function automatic logic [XLEN-1:0] resolve(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] rf_val,
        input logic            slot_valid,
        input logic            slot_wr,
        input logic [AW-1:0]   slot_rd,
        input logic [XLEN-1:0] fwd_val,
        input logic            wen,
        input logic [AW-1:0]   waddr,
        input logic [XLEN-1:0] wdata
    );
        logic [XLEN-1:0] r;
        if (addr == '0)
            r = '0;
        else if (slot_valid && slot_wr && (slot_rd == addr))
            r = fwd_val;
        else if (wen && (waddr == addr))
            r = wdata;
        else
            r = rf_val;
        return r;
    endfunction

    // ---- stage p0: operand resolution and handshake (combinational) ----
    always_comb begin
        rs1_val_p0 = resolve(in_rs1, regs[in_rs1], out_valid, out_reg_write,
                             out_rd, ex_result, wb_en, wb_addr, wb_data);
        rs2_val_p0 = resolve(in_rs2, regs[in_rs2], out_valid, out_reg_write,
                             out_rd, ex_result, wb_en, wb_addr, wb_data);
        b_val_p0   = in_alu_src ? in_imm : rs2_val_p0;
    end

    assign in_ready  = (~out_valid | out_ready) & ~flush;
    assign accept_p0 = in_valid & in_ready;

    // Register file; x0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // ---- stage p1: output slot ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_alu_control <= 3'b000;
            out_A           <= '0;
            out_B           <= '0;
            out_rs2_val     <= '0;
            out_rd          <= '0;
            out_reg_write   <= 1'b0;
        end else if (flush) begin
            // Clearing reg_write too keeps a killed slot from forwarding.
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
        end else if (accept_p0) begin
            out_valid       <= 1'b1;
            out_alu_control <= in_alu_control;
            out_A           <= rs1_val_p0;
            out_B           <= b_val_p0;
            out_rs2_val     <= rs2_val_p0;
            out_rd          <= in_rd;
            out_reg_write   <= in_reg_write;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm;
    logic        in_alu_src;
    logic [2:0]  in_alu_control;
    logic        in_reg_write;
    logic [31:0] ex_result;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [2:0]  out_alu_control;
    logic [31:0] out_A, out_B, out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_reg_write;

    int vectors;
    int miscompares;

    id_ex_operand_stage #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .in_alu_src(in_alu_src),
        .in_alu_control(in_alu_control), .in_reg_write(in_reg_write),
        .ex_result(ex_result),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_alu_control(out_alu_control),
        .out_A(out_A), .out_B(out_B), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_reg_write(out_reg_write)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic src, input logic [31:0] imm, input logic [2:0] ctrl,
                         input logic rw);
        in_valid       = 1'b1;
        in_rs1         = rs1;
        in_rs2         = rs2;
        in_rd          = rd;
        in_alu_src     = src;
        in_imm         = imm;
        in_alu_control = ctrl;
        in_reg_write   = rw;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
        in_alu_src = 1'b0; in_alu_control = 3'b000; in_reg_write = 1'b0;
        ex_result = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_A", out_A, 32'd0);
        check("rst_ctrl", {29'd0, out_alu_control}, 32'd0);
        check("rst_regwr", {31'd0, out_reg_write}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // Read after reset
        instr(5'd5, 5'd6, 5'd1, 1'b0, 32'd0, 3'b010, 1'b0);
        step();
        check("rd_valid", {31'd0, out_valid}, 32'd1);
        check("rd_A", out_A, 32'd0);
        check("rd_B", out_B, 32'd0);
        check("rd_ctrl", {29'd0, out_alu_control}, 32'd2);

        // Write-back bypass on x3
        instr(5'd3, 5'd0, 5'd2, 1'b0, 32'd0, 3'b000, 1'b0);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
        step();
        check("wbbyp_A", out_A, 32'h1234);
        check("wbbyp_B", out_B, 32'd0);
        wb_en = 1'b0;
        instr(5'd0, 5'd3, 5'd2, 1'b0, 32'd0, 3'b001, 1'b0);
        step();
        check("x3_B", out_B, 32'h1234);
        check("x3_rs2", out_rs2_val, 32'h1234);
        check("x3_A", out_A, 32'd0);
        check("x3_ctrl", {29'd0, out_alu_control}, 32'd1);

        // EX forward beats write-back
        instr(5'd0, 5'd0, 5'd7, 1'b0, 32'd0, 3'b010, 1'b1);
        step();
        check("fwd_slot_rd", {27'd0, out_rd}, 32'd7);
        check("fwd_slot_rw", {31'd0, out_reg_write}, 32'd1);
        ex_result = 32'hAAAA;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h5555;
        instr(5'd7, 5'd7, 5'd8, 1'b0, 32'd0, 3'b010, 1'b0);
        step();
        check("fwd_A", out_A, 32'hAAAA);
        check("fwd_B", out_B, 32'hAAAA);
        wb_en = 1'b0;
        instr(5'd7, 5'd0, 5'd8, 1'b0, 32'd0, 3'b010, 1'b0);
        step();
        check("x7_A", out_A, 32'h5555);

        // Immediate select, x0 write ignored
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        instr(5'd0, 5'd3, 5'd9, 1'b1, 32'hFFFFFFFC, 3'b010, 1'b0);
        step();
        check("imm_A", out_A, 32'd0);
        check("imm_B", out_B, 32'hFFFFFFFC);
        check("imm_rs2", out_rs2_val, 32'h1234);
        wb_en = 1'b0;
        instr(5'd0, 5'd0, 5'd9, 1'b0, 32'd0, 3'b011, 1'b0);
        step();
        check("x0_B", out_B, 32'd0);
        check("x0_ctrl", {29'd0, out_alu_control}, 32'd3);

        // Stall: outputs hold, in_ready low
        out_ready = 1'b0;
        instr(5'd3, 5'd0, 5'd9, 1'b0, 32'd0, 3'b110, 1'b0);
        #1;
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ready", {31'd0, in_ready}, 32'd0);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_A", out_A, 32'd0);
            check("stall_ctrl", {29'd0, out_alu_control}, 32'd3);
        end
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("unstall_A", out_A, 32'h1234);
        check("unstall_ctrl", {29'd0, out_alu_control}, 32'd6);
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Flush: slot killed, incoming dropped, write-back still lands
        instr(5'd3, 5'd0, 5'd10, 1'b0, 32'd0, 3'b111, 1'b1);
        step();
        check("pre_flush_valid", {31'd0, out_valid}, 32'd1);
        check("pre_flush_rw", {31'd0, out_reg_write}, 32'd1);
        flush = 1'b1;
        instr(5'd7, 5'd0, 5'd11, 1'b0, 32'd0, 3'b100, 1'b1);
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_rw", {31'd0, out_reg_write}, 32'd0);
        flush = 1'b0; wb_en = 1'b0;
        instr(5'd4, 5'd0, 5'd12, 1'b0, 32'd0, 3'b001, 1'b0);
        step();
        check("flush_wb_x4", out_A, 32'h4444);
        check("post_flush_valid", {31'd0, out_valid}, 32'd1);

        // Asynchronous reset during a stall
        out_ready = 1'b0;
        in_valid = 1'b0;
        step();
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_A", out_A, 32'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        instr(5'd3, 5'd0, 5'd1, 1'b0, 32'd0, 3'b010, 1'b0);
        step();
        check("arst_x3", out_A, 32'd0);
        check("arst_after_valid", {31'd0, out_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute boundary feeding the 3-bit-controlled ALU.
- Holds the 32-entry integer register file and reads rs1/rs2 with write-back bypass and EX-result forwarding.
- Selects register or immediate for operand B, and registers operands plus ALU control into a valid/ready pipeline slot whose outputs drive the ALU's alu_control, A and B inputs directly.

Parameters:
XLEN, 32, datapath width of registers and operands
NREG, 32, number of architectural registers; address width is log2(NREG)=5

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage can accept this cycle
in_rs1  input  5  source register 1 address
in_rs2  input  5  source register 2 address
in_rd  input  5  destination register address
in_imm  input  XLEN  sign-extended immediate
in_alu_src  input  1  1: operand B = in_imm, 0: operand B = rs2 value
in_alu_control  input  3  ALU op code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 SLL)
in_reg_write  input  1  instruction writes rd
ex_result  input  XLEN  combinational ALU result of instruction currently in this stage's output slot
wb_en  input  1  write-back enable
wb_addr  input  5  write-back register address
wb_data  input  XLEN  write-back data
flush  input  1  synchronous kill of slot and incoming instruction
out_ready  input  1  downstream accepts slot this cycle
out_valid  output  1  slot holds a valid instruction
out_alu_control  output  3  registered ALU op code
out_A  output  XLEN  registered operand A
out_B  output  XLEN  registered operand B
out_rs2_val  output  XLEN  registered rs2 value (store data), independent of in_alu_src
out_rd  output  5  registered destination
out_reg_write  output  1  registered write flag

Behaviour:
- Reset (rst_n=0, asynchronous): all registers x0..x31 = 0; out_valid=0; out_alu_control=000; out_A=out_B=out_rs2_val=0; out_rd=0; out_reg_write=0.
- Register file: write on rising edge when wb_en=1 and wb_addr!=0. x0 always reads 0, and writes to x0 are ignored.
- Operand resolution per source (rs1 and rs2 independently), in priority order:
  1. Address 0 gives 0.
  2. EX forward: out_valid & out_reg_write & out_rd==addr gives ex_result.
  3. Write-back bypass: wb_en & wb_addr==addr gives wb_data.
  4. Otherwise the register file contents.
- Operand select: A = resolved rs1. B = in_imm if in_alu_src=1, else resolved rs2. rs2_val = resolved rs2 always.
- Handshake:
  - in_ready = (~out_valid | out_ready) & ~flush, combinational.
  - Accept when in_valid & in_ready. On the next edge, the slot loads A, B, rs2_val, alu_control, rd, reg_write, and out_valid=1.
  - If out_ready=1 and no accept, out_valid drops to 0 on the next edge.
  - If out_valid=1 and out_ready=0, the slot holds all outputs stable (stall).
- Latency: one cycle from accept to out_valid.
- Throughput: one instruction per cycle while out_ready=1.
- Flush:
  - On the next edge out_valid=0 and out_reg_write=0; other slot fields are don't-care.
  - The incoming instruction is not accepted.
  - Flush overrides stall and accept.
  - Register-file write in the same cycle still occurs.
- Simultaneous write-back and read of the same register: the read sees wb_data in the same cycle (write-through).
- Reset asserted mid-stall clears the slot immediately. Deassertion is synchronized externally; the first edge after release behaves normally.
- No arithmetic is performed here; all widths pass through unchanged.

Test Plan:
- Reset then read: after rst_n release, send rs1=5, rs2=6, alu_src=0, ctrl=010 -> next cycle out_valid=1, out_A=0, out_B=0, out_alu_control=010.
- Write-back bypass: wb_en=1, wb_addr=3, wb_data=0x1234 in the same cycle as accept of rs1=3 -> out_A=0x1234; a later read of x3 also returns 0x1234.
- EX forward priority: slot holds rd=7, reg_write=1, ex_result=0xAAAA; x7 is being written back with 0x5555; accept rs1=7, rs2=7, alu_src=0 -> out_A=out_B=0xAAAA.
- Immediate and x0: write x0=0xFFFF via wb, then accept rs1=0, alu_src=1, imm=0xFFFFFFFC -> out_A=0, out_B=0xFFFFFFFC, out_rs2_val=resolved rs2.
- Stall: out_valid=1, out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 and outputs unchanged. On out_ready=1, the next instruction loads on the following edge.
- Flush: accept an instruction, then assert flush with in_valid=1 -> next cycle out_valid=0, out_reg_write=0, in_ready=0 during flush, no capture; async rst_n pulse mid-stall clears out_valid without a clock.
